// File: rtl/approx_err_monitor.sv
// Streaming error-statistics engine for an approximate W-bit adder: computes the signed
// error per accepted sample and accumulates count, max |err|, sum err, sum |err|, sum err^2.
module approx_err_monitor #(
  parameter int W     = 16,
  parameter int CNT_W = 24
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [CNT_W-1:0]          num_samples,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [W-1:0]              IN1,
  input  logic [W-1:0]              IN2,
  input  logic [W:0]                APPROX,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_W-1:0]          sample_cnt,
  output logic [CNT_W-1:0]          err_cnt,
  output logic [W:0]                max_abs_err,
  output logic [W+2+CNT_W-1:0]      sum_err,
  output logic [W+1+CNT_W-1:0]      sum_abs_err,
  output logic [2*(W+1)+CNT_W-1:0]  sum_sq_err
);

  localparam int SE_W = W + 2 + CNT_W;
  localparam int SA_W = W + 1 + CNT_W;
  localparam int SQ_W = 2 * (W + 1);
  localparam int SS_W = SQ_W + CNT_W;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic [W:0]          max_abs_q, max_abs_d;
  logic [SE_W-1:0]     sum_err_q, sum_err_d;
  logic [SA_W-1:0]     sum_abs_q, sum_abs_d;
  logic [SS_W-1:0]     sum_sq_q, sum_sq_d;

  logic                s1_valid_q, s1_valid_d;
  logic signed [W+1:0] s1_err_q, s1_err_d;
  logic [W:0]          s1_abs_q, s1_abs_d;
  logic                s2_valid_q, s2_valid_d;
  logic signed [W+1:0] s2_err_q, s2_err_d;
  logic [W:0]          s2_abs_q, s2_abs_d;
  logic [SQ_W-1:0]     s2_sq_q, s2_sq_d;
  logic                s2_nz_q, s2_nz_d;

  logic [W:0]          exact;
  logic signed [W+1:0] err;
  logic [W+1:0]        err_mag;
  logic                accept;
  logic                clear;

  always_comb begin
    exact   = {1'b0, IN1} + {1'b0, IN2};
    err     = $signed({1'b0, APPROX}) - $signed({1'b0, exact});
    err_mag = err[W+1] ? (~err + 1'b1) : err;
    accept  = in_valid && in_ready_q;
    clear   = 1'b0;

    state_d      = state_q;
    remaining_d  = remaining_q;
    sample_cnt_d = sample_cnt_q;
    done_d       = 1'b0;

    s1_valid_d = accept;
    s1_err_d   = accept ? err : s1_err_q;
    s1_abs_d   = accept ? err_mag[W:0] : s1_abs_q;

    s2_valid_d = s1_valid_q;
    s2_err_d   = s1_valid_q ? s1_err_q : s2_err_q;
    s2_abs_d   = s1_valid_q ? s1_abs_q : s2_abs_q;
    s2_sq_d    = s1_valid_q ? SQ_W'(s1_abs_q) * SQ_W'(s1_abs_q) : s2_sq_q;
    s2_nz_d    = s1_valid_q ? (s1_abs_q != '0) : s2_nz_q;

    err_cnt_d = err_cnt_q;
    max_abs_d = max_abs_q;
    sum_err_d = sum_err_q;
    sum_abs_d = sum_abs_q;
    sum_sq_d  = sum_sq_q;
    if (s2_valid_q) begin
      err_cnt_d = err_cnt_q + CNT_W'(s2_nz_q);
      if (s2_abs_q >= max_abs_q) max_abs_d = s2_abs_q;
      sum_err_d = sum_err_q + {{CNT_W{s2_err_q[W+1]}}, s2_err_q};
      sum_abs_d = sum_abs_q + SA_W'(s2_abs_q);
      sum_sq_d  = sum_sq_q + SS_W'(s2_sq_q);
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          clear       = 1'b1;
          remaining_d = num_samples;
          if (num_samples == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (accept) begin
          remaining_d  = remaining_q - CNT_W'(1);
          sample_cnt_d = sample_cnt_q + CNT_W'(1);
          if (remaining_q == CNT_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!s1_valid_q && !s2_valid_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Pipeline is empty whenever start is honoured, so clearing cannot drop a sample.
    if (clear) begin
      sample_cnt_d = '0;
      err_cnt_d    = '0;
      max_abs_d    = '0;
      sum_err_d    = '0;
      sum_abs_d    = '0;
      sum_sq_d     = '0;
    end

    in_ready_d = (state_d == RUN) && (remaining_d != '0);
    busy_d     = (state_d == RUN) || (state_d == DRAIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      remaining_q  <= '0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      max_abs_q    <= '0;
      sum_err_q    <= '0;
      sum_abs_q    <= '0;
      sum_sq_q     <= '0;
      s1_valid_q   <= 1'b0;
      s1_err_q     <= '0;
      s1_abs_q     <= '0;
      s2_valid_q   <= 1'b0;
      s2_err_q     <= '0;
      s2_abs_q     <= '0;
      s2_sq_q      <= '0;
      s2_nz_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      sample_cnt_q <= sample_cnt_d;
      err_cnt_q    <= err_cnt_d;
      max_abs_q    <= max_abs_d;
      sum_err_q    <= sum_err_d;
      sum_abs_q    <= sum_abs_d;
      sum_sq_q     <= sum_sq_d;
      s1_valid_q   <= s1_valid_d;
      s1_err_q     <= s1_err_d;
      s1_abs_q     <= s1_abs_d;
      s2_valid_q   <= s2_valid_d;
      s2_err_q     <= s2_err_d;
      s2_abs_q     <= s2_abs_d;
      s2_sq_q      <= s2_sq_d;
      s2_nz_q      <= s2_nz_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign sample_cnt  = sample_cnt_q;
  assign err_cnt     = err_cnt_q;
  assign max_abs_err = max_abs_q;
  assign sum_err     = sum_err_q;
  assign sum_abs_err = sum_abs_q;
  assign sum_sq_err  = sum_sq_q;

endmodule

// File: tb/tb_approx_err_monitor.sv
// Directed + randomized bench for approx_err_monitor; expected statistics come from an
// integer-arithmetic model over the queue of samples fed in each run.
module tb_approx_err_monitor;

  localparam int W     = 16;
  localparam int CNT_W = 24;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      start = 1'b0;
  logic [CNT_W-1:0]          num_samples = '0;
  logic                      in_valid = 1'b0;
  logic                      in_ready;
  logic [W-1:0]              IN1 = '0;
  logic [W-1:0]              IN2 = '0;
  logic [W:0]                APPROX = '0;
  logic                      busy;
  logic                      done;
  logic [CNT_W-1:0]          sample_cnt;
  logic [CNT_W-1:0]          err_cnt;
  logic [W:0]                max_abs_err;
  logic [W+2+CNT_W-1:0]      sum_err;
  logic [W+1+CNT_W-1:0]      sum_abs_err;
  logic [2*(W+1)+CNT_W-1:0]  sum_sq_err;

  approx_err_monitor #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .IN1(IN1), .IN2(IN2), .APPROX(APPROX),
    .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
    .max_abs_err(max_abs_err), .sum_err(sum_err), .sum_abs_err(sum_abs_err),
    .sum_sq_err(sum_sq_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails   = 0;

  bit [15:0] q1[$];
  bit [15:0] q2[$];
  bit [16:0] qa[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit [15:0] a, input bit [15:0] b, input bit [16:0] ap);
    q1.push_back(a); q2.push_back(b); qa.push_back(ap);
  endtask

  task automatic clear_q();
    q1.delete(); q2.delete(); qa.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_cnt"},  64'(sample_cnt), 0);
    check({tag, "_ecnt"}, 64'(err_cnt), 0);
    check({tag, "_max"},  64'(max_abs_err), 0);
    check({tag, "_se"},   64'(sum_err), 0);
    check({tag, "_sa"},   64'(sum_abs_err), 0);
    check({tag, "_sq"},   64'(sum_sq_err), 0);
  endtask

  // Reference statistics over every queued sample, straight from the error definitions.
  task automatic check_model(input string tag);
    int     e, a, nz, mx;
    longint se, sa, sq;
    logic [W+2+CNT_W-1:0] se_t;
    nz = 0; mx = 0; se = 0; sa = 0; sq = 0;
    foreach (qa[i]) begin
      e  = int'(qa[i]) - (int'(q1[i]) + int'(q2[i]));
      a  = (e < 0) ? -e : e;
      if (e != 0) nz++;
      if (a > mx) mx = a;
      se += e;
      sa += a;
      sq += longint'(a) * longint'(a);
    end
    se_t = se[W+2+CNT_W-1:0];
    check({tag, "_cnt"},  64'(sample_cnt), 64'(qa.size()));
    check({tag, "_ecnt"}, 64'(err_cnt), 64'(nz));
    check({tag, "_max"},  64'(max_abs_err), 64'(mx));
    check({tag, "_se"},   64'(sum_err), 64'(se_t));
    check({tag, "_sa"},   64'(sum_abs_err), 64'(sa));
    check({tag, "_sq"},   64'(sum_sq_err), 64'(sq));
  endtask

  // vmode 0: always valid, 1: fixed 1,0,0,1,1,0,1 pattern, 2: random valid.
  task automatic do_run(input string tag, input int n, input int vmode, input bit poke_start);
    bit pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    bit v, rdy;
    int idx, cyc;
    start = 1'b1; num_samples = CNT_W'(n);
    @(posedge clk); #1;
    start = 1'b0; num_samples = CNT_W'($urandom);
    check({tag, "_busy0"}, 64'(busy), 64'(n != 0));
    check({tag, "_rdy0"},  64'(in_ready), 64'(n != 0));
    check({tag, "_done0"}, 64'(done), 64'(n == 0));
    check_zero({tag, "_clr"});
    if (n == 0) begin
      @(posedge clk); #1;
      check({tag, "_done1"}, 64'(done), 0);
      check({tag, "_rdy1"},  64'(in_ready), 0);
      return;
    end
    idx = 0; cyc = 0;
    while (idx < n && cyc < 1000) begin
      v = (vmode == 0) ? 1'b1 : (vmode == 1) ? pat[cyc % 7] : 1'($urandom_range(0, 1));
      in_valid = v;
      IN1    = v ? q1[idx] : 16'($urandom);
      IN2    = v ? q2[idx] : 16'($urandom);
      APPROX = v ? qa[idx] : 17'($urandom);
      check({tag, "_rdy_run"}, 64'(in_ready), 1);
      if (poke_start && cyc == 1) begin
        start = 1'b1; num_samples = CNT_W'(2);
      end
      rdy = in_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (v && rdy) idx++;
      check({tag, "_scnt"}, 64'(sample_cnt), 64'(idx));
      cyc++;
    end
    in_valid = 1'b0;
    if (idx < n) check({tag, "_timeout"}, 64'(idx), 64'(n));
    check({tag, "_rdy_fall"}, 64'(in_ready), 0);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      check({tag, "_drain_rdy"},  64'(in_ready), 0);
      check({tag, "_drain_done"}, 64'(done), 64'(k == 3));
      check({tag, "_drain_busy"}, 64'(busy), 64'(k < 3));
    end
    check_model(tag);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 64'(done), 0);
    check_model({tag, "_hold"});
  endtask

  initial begin
    bit [16:0] ex;
    int n;
    // Reset with start held high: start must be ignored.
    start = 1'b1; num_samples = CNT_W'(5);
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy", 64'(in_ready), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check_zero("rst");
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", 64'(busy), 0);

    clear_q();
    push(16'h0000, 16'h0000, 17'h00000);
    push(16'hFFFF, 16'hFFFF, 17'h1FFFE);
    push(16'h1234, 16'h0001, 17'h01235);
    do_run("exact", 3, 0, 1'b0);

    clear_q();
    push(16'hFFFF, 16'h0001, 17'h00000);
    do_run("worst", 1, 0, 1'b0);
    check("worst_se_lit", 64'($signed(sum_err)), 64'(-65536));
    check("worst_sq_lit", 64'(sum_sq_err), 64'd4294967296);

    clear_q();
    push(16'd10, 16'd0, 17'd13);
    push(16'd10, 16'd0, 17'd5);
    push(16'd10, 16'd0, 17'd10);
    push(16'd10, 16'd0, 17'd11);
    do_run("mixed", 4, 0, 1'b0);
    check("mixed_se_lit", 64'($signed(sum_err)), 64'(-1));
    check("mixed_sq_lit", 64'(sum_sq_err), 64'd35);
    do_run("mixed_thr", 4, 1, 1'b0);

    clear_q();
    do_run("zero", 0, 0, 1'b0);

    clear_q();
    for (int i = 0; i < 6; i++)
      push(16'($urandom), 16'($urandom), 17'($urandom));
    do_run("poke", 6, 2, 1'b1);

    // Reset after two acceptances in RUN.
    clear_q();
    start = 1'b1; num_samples = CNT_W'(5);
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b1; IN1 = 16'd100; IN2 = 16'd1; APPROX = 17'd90;
    repeat (2) @(posedge clk);
    #1;
    check("mid_scnt", 64'(sample_cnt), 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    check("mid_rdy", 64'(in_ready), 0);
    check("mid_busy", 64'(busy), 0);
    check("mid_done", 64'(done), 0);
    check_zero("mid");
    repeat (3) @(posedge clk);
    #1;
    check_zero("mid_flush");
    push(16'h00FF, 16'h0F00, 17'h00FFF);
    do_run("post_rst", 1, 0, 1'b0);

    // Randomized runs with a mix of exact, small-error and arbitrary approximate sums.
    for (int r = 0; r < 6; r++) begin
      clear_q();
      n = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) begin
        bit [15:0] a, b;
        a  = 16'($urandom);
        b  = 16'($urandom);
        ex = {1'b0, a} + {1'b0, b};
        case ($urandom_range(0, 2))
          0: push(a, b, ex);
          1: push(a, b, ex + 17'($urandom_range(0, 64)) - 17'd32);
          default: push(a, b, 17'($urandom));
        endcase
      end
      do_run($sformatf("rnd%0d", r), n, (r % 2 == 0) ? 2 : 0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
